// File: rtl/synth_voice_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
// Contents: note/velocity widths, event payload struct, FSM state enum,
// allocation priority codes and a helper that classifies one voice.
package synth_voice_pkg;

  localparam int unsigned NOTE_W = 7;
  localparam int unsigned VEL_W  = 7;
  localparam int unsigned PRI_W  = 3;

  // Latched note event
  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  vel;
  } ev_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_GAP    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Higher code = stronger claim on a voice
  typedef logic [PRI_W-1:0] pri_t;
  localparam pri_t PRI_NONE   = 3'd0;
  localparam pri_t PRI_STEAL  = 3'd1;
  localparam pri_t PRI_REL    = 3'd2;
  localparam pri_t PRI_FREE   = 3'd3;
  localparam pri_t PRI_RETRIG = 3'd4;

  // Classify one voice as an allocation candidate for a note-on
  function automatic pri_t voice_pri(input logic gated, input logic match,
                                     input logic idle, input logic steal_ok);
    if (gated && match) return PRI_RETRIG;
    if (!gated)         return idle ? PRI_FREE : PRI_REL;
    return steal_ok ? PRI_STEAL : PRI_NONE;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI parser (master) and the allocator (slave).
// Signals: ev_valid, ev_ready, ev_on (1 = note-on), ev_note, ev_vel.
interface voice_allocator_if;
  import synth_voice_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [VEL_W-1:0]  ev_vel;

  modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);

endinterface

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters. On i_commit the committed voice is
// cleared to 0 and every other voice ages by one, saturating at all-ones.
// Ports: clk, rst_n (sync, active-low, ages reset to max), i_commit,
// i_voice (committed index), o_age (age per voice).
module voice_age_tracker #(
  parameter int unsigned NVOICE = 8,
  parameter int unsigned VW     = 3,
  parameter int unsigned AGE_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_commit,
  input  logic [VW-1:0]    i_voice,
  output logic [AGE_W-1:0] o_age [NVOICE]
);

  logic [AGE_W-1:0] r_age [NVOICE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NVOICE; i++) r_age[i] <= '1;
    end else if (i_commit) begin
      for (int i = 0; i < NVOICE; i++) begin
        if (VW'(i) == i_voice)   r_age[i] <= '0;
        else if (r_age[i] != '1) r_age[i] <= r_age[i] + AGE_W'(1);
      end
    end
  end

  assign o_age = r_age;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. Accepts note-on/off events over voice_allocator_if,
// scans the voices one per clock and assigns note-ons by priority
// (retrigger > free > oldest releasing > oldest gated), drives per-voice GATE
// and latched note/velocity. Build option: VOICE_STEAL_EN enables stealing the
// oldest gated voice; without it a note-on with no candidate is dropped.
// Ports: clk, rst_n (sync active-low), ena (envelope strobe), ev (slave modport),
// env_idle, gate, v_note, v_vel, alloc_stb, alloc_voice, drop_stb.
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int unsigned NVOICE = 8,
  parameter int unsigned VW     = 3,
  parameter int unsigned AGE_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  voice_allocator_if.slave         ev,
  input  logic [NVOICE-1:0]        env_idle,
  output logic [NVOICE-1:0]        gate,
  output logic [NVOICE*NOTE_W-1:0] v_note,
  output logic [NVOICE*VEL_W-1:0]  v_vel,
  output logic                     alloc_stb,
  output logic [VW-1:0]            alloc_voice,
  output logic                     drop_stb
);

`ifdef VOICE_STEAL_EN
  localparam logic STEAL_OK = 1'b1;
`else
  localparam logic STEAL_OK = 1'b0;
`endif
  localparam logic [VW-1:0] LAST_IDX = VW'(NVOICE - 1);

  state_t            r_state, w_state_nxt;
  logic [VW-1:0]     r_idx, w_idx_nxt;
  pri_t              r_best_pri, w_best_pri_nxt;
  logic [VW-1:0]     r_best_idx, w_best_idx_nxt;
  logic [AGE_W-1:0]  r_best_age, w_best_age_nxt;
  ev_t               r_ev, w_ev_nxt;
  logic [NVOICE-1:0] r_gate, w_gate_nxt;
  logic [NOTE_W-1:0] r_v_note [NVOICE];
  logic [NOTE_W-1:0] w_note_nxt [NVOICE];
  logic [VEL_W-1:0]  r_v_vel [NVOICE];
  logic [VEL_W-1:0]  w_vel_nxt [NVOICE];
  logic              r_alloc_stb, w_alloc_stb_nxt;
  logic [VW-1:0]     r_alloc_voice, w_alloc_voice_nxt;
  logic              r_drop_stb, w_drop_stb_nxt;
  logic              r_ev_ready, w_ev_ready_nxt;

  logic [AGE_W-1:0]  w_age [NVOICE];
  logic              w_commit;
  logic              w_match;
  pri_t              w_cur_pri;
  logic              w_better;

  assign w_commit = (r_state == ST_COMMIT);

  voice_age_tracker #(.NVOICE(NVOICE), .VW(VW), .AGE_W(AGE_W)) u_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_commit (w_commit),
    .i_voice  (r_best_idx),
    .o_age    (w_age)
  );

  // Candidate evaluation of the voice currently being visited
  always_comb begin
    w_match   = r_gate[r_idx] && (r_v_note[r_idx] == r_ev.note);
    w_cur_pri = voice_pri(r_gate[r_idx], w_match, env_idle[r_idx], STEAL_OK);
    // Age only breaks ties for releasing/stolen voices; strict > keeps lowest index
    w_better  = (w_cur_pri > r_best_pri) ||
                ((w_cur_pri == r_best_pri) &&
                 ((w_cur_pri == PRI_REL) || (w_cur_pri == PRI_STEAL)) &&
                 (w_age[r_idx] > r_best_age));
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_best_pri_nxt    = r_best_pri;
    w_best_idx_nxt    = r_best_idx;
    w_best_age_nxt    = r_best_age;
    w_ev_nxt          = r_ev;
    w_gate_nxt        = r_gate;
    w_note_nxt        = r_v_note;
    w_vel_nxt         = r_v_vel;
    w_alloc_stb_nxt   = 1'b0;
    w_alloc_voice_nxt = r_alloc_voice;
    w_drop_stb_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (ev.ev_valid && r_ev_ready) begin
          w_ev_nxt       = '{on: ev.ev_on, note: ev.ev_note, vel: ev.ev_vel};
          w_idx_nxt      = '0;
          w_best_pri_nxt = PRI_NONE;
          w_best_idx_nxt = '0;
          w_best_age_nxt = '0;
          w_state_nxt    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (r_ev.on) begin
          if (w_better) begin
            w_best_pri_nxt = w_cur_pri;
            w_best_idx_nxt = r_idx;
            w_best_age_nxt = w_age[r_idx];
          end
        end else if (w_match) begin
          w_gate_nxt[r_idx] = 1'b0;
        end
        w_idx_nxt = r_idx + VW'(1);
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = '0;
          if (!r_ev.on) begin
            w_state_nxt = ST_IDLE;
          end else if (w_best_pri_nxt == PRI_NONE) begin
            w_drop_stb_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else if ((w_best_pri_nxt == PRI_RETRIG) || (w_best_pri_nxt == PRI_STEAL)) begin
            // Drop GATE so the envelope sees a release before re-attack
            w_gate_nxt[w_best_idx_nxt] = 1'b0;
            w_state_nxt                = ST_GAP;
          end else begin
            w_state_nxt = ST_COMMIT;
          end
        end
      end
      ST_GAP: begin
        if (ena) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_gate_nxt[r_best_idx] = 1'b1;
        w_note_nxt[r_best_idx] = r_ev.note;
        w_vel_nxt[r_best_idx]  = r_ev.vel;
        w_alloc_stb_nxt        = 1'b1;
        w_alloc_voice_nxt      = r_best_idx;
        w_state_nxt            = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_ev_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_best_pri    <= PRI_NONE;
      r_best_idx    <= '0;
      r_best_age    <= '0;
      r_ev          <= '0;
      r_gate        <= '0;
      r_v_note      <= '{default: '0};
      r_v_vel       <= '{default: '0};
      r_alloc_stb   <= 1'b0;
      r_alloc_voice <= '0;
      r_drop_stb    <= 1'b0;
      r_ev_ready    <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_best_pri    <= w_best_pri_nxt;
      r_best_idx    <= w_best_idx_nxt;
      r_best_age    <= w_best_age_nxt;
      r_ev          <= w_ev_nxt;
      r_gate        <= w_gate_nxt;
      r_v_note      <= w_note_nxt;
      r_v_vel       <= w_vel_nxt;
      r_alloc_stb   <= w_alloc_stb_nxt;
      r_alloc_voice <= w_alloc_voice_nxt;
      r_drop_stb    <= w_drop_stb_nxt;
      r_ev_ready    <= w_ev_ready_nxt;
    end
  end

  for (genvar i = 0; i < NVOICE; i++) begin : g_pack
    assign v_note[i*NOTE_W +: NOTE_W] = r_v_note[i];
    assign v_vel[i*VEL_W +: VEL_W]    = r_v_vel[i];
  end

  assign gate        = r_gate;
  assign alloc_stb   = r_alloc_stb;
  assign alloc_voice = r_alloc_voice;
  assign drop_stb    = r_drop_stb;
  assign ev.ev_ready = r_ev_ready;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (8 voices). Covers reset,
// first allocation latency, retrigger gap held by ena, note-off, stealing or
// dropping when all voices are gated (VOICE_STEAL_EN), oldest-releasing
// selection and reset during a scan.
module tb_voice_allocator;
  import synth_voice_pkg::*;

  localparam int unsigned NVOICE = 8;
  localparam int unsigned VW     = 3;
  localparam int unsigned AGE_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ena;
  logic [NVOICE-1:0]        env_idle;
  logic [NVOICE-1:0]        gate;
  logic [NVOICE*NOTE_W-1:0] v_note;
  logic [NVOICE*VEL_W-1:0]  v_vel;
  logic                     alloc_stb;
  logic [VW-1:0]            alloc_voice;
  logic                     drop_stb;

  voice_allocator_if ev_if ();

  voice_allocator #(.NVOICE(NVOICE), .VW(VW), .AGE_W(AGE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ev          (ev_if),
    .env_idle    (env_idle),
    .gate        (gate),
    .v_note      (v_note),
    .v_vel       (v_vel),
    .alloc_stb   (alloc_stb),
    .alloc_voice (alloc_voice),
    .drop_stb    (drop_stb)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  logic        got_alloc, got_drop, seen;
  logic [7:0]  low_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NOTE_W-1:0] note_of(input int i);
    return v_note[i*NOTE_W +: NOTE_W];
  endfunction

  function automatic logic [VEL_W-1:0] vel_of(input int i);
    return v_vel[i*VEL_W +: VEL_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one event; returns just after the accepting edge
  task automatic send(input logic on, input logic [NOTE_W-1:0] note, input logic [VEL_W-1:0] vel);
    int n = 0;
    while (!ev_if.ev_ready && n < 50) begin
      tick();
      n++;
    end
    if (!ev_if.ev_ready) check("ready_timeout", 64'd0, 64'd1);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = note;
    ev_if.ev_vel   = vel;
    tick();
    ev_if.ev_valid = 1'b0;
  endtask

  // Count clocks after accept until alloc_stb or drop_stb
  task automatic wait_result(output int c, output logic ga, output logic gd, output logic [7:0] lows);
    c = 0; ga = 1'b0; gd = 1'b0; lows = '0;
    while (c < 40 && !ga && !gd) begin
      tick();
      c++;
      lows |= ~gate;
      ga = alloc_stb;
      gd = drop_stb;
    end
    if (!ga && !gd) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic note_on(input logic [NOTE_W-1:0] note, input logic [VEL_W-1:0] vel);
    send(1'b1, note, vel);
    wait_result(cyc, got_alloc, got_drop, low_seen);
  endtask

  task automatic note_off(input logic [NOTE_W-1:0] note);
    send(1'b0, note, '0);
    repeat (NVOICE + 1) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    env_idle = 8'hFF;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on = 1'b0;
    ev_if.ev_note = '0;
    ev_if.ev_vel = '0;
    repeat (3) tick();

    // Reset state
    check("rst_gate", gate, 8'h00);
    check("rst_note", v_note, 0);
    check("rst_ready", ev_if.ev_ready, 1);
    check("rst_stbs", {alloc_stb, drop_stb}, 0);
    rst_n = 1'b1;
    tick();

    // First note-on goes to voice 0 after NVOICE+1 clocks
    note_on(7'd60, 7'd100);
    check("t1_latency", cyc, 9);
    check("t1_alloc", got_alloc, 1);
    check("t1_voice", alloc_voice, 0);
    check("t1_gate", gate, 8'h01);
    check("t1_note0", note_of(0), 60);
    check("t1_vel0", vel_of(0), 100);

    // Retrigger same note: gate held low until an ena clock
    ena = 1'b0;
    send(1'b1, 7'd60, 7'd50);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= alloc_stb;
    end
    check("t3_no_stb_in_gap", seen, 0);
    check("t3_gate_low", gate, 8'h00);
    ena = 1'b1;
    wait_result(cyc, got_alloc, got_drop, low_seen);
    check("t3_latency_after_ena", cyc, 2);
    check("t3_voice", alloc_voice, 0);
    check("t3_gate", gate, 8'h01);
    check("t3_vel0", vel_of(0), 50);

    // Note-ons fill free voices, note-off clears only the matching voice
    note_on(7'd62, 7'd90);
    check("t2_voice62", alloc_voice, 1);
    note_on(7'd64, 7'd80);
    check("t2_voice64", alloc_voice, 2);
    check("t2_gate3", gate, 8'h07);
    note_off(7'd62);
    check("t2_gate_off", gate, 8'h05);
    check("t2_note1_kept", note_of(1), 62);
    note_off(7'd99);
    check("t2_off_nomatch", gate, 8'h05);

    // All voices gated: steal oldest or drop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      note_on(7'(60 + i), 7'd64);
      check("fill_voice", alloc_voice, 64'(i));
    end
    check("fill_gate", gate, 8'hFF);
    note_on(7'd70, 7'd127);
`ifdef VOICE_STEAL_EN
    check("t4_latency", cyc, 10);
    check("t4_alloc", got_alloc, 1);
    check("t4_voice", alloc_voice, 0);
    check("t4_gap_seen", low_seen[0], 1);
    check("t4_gate", gate, 8'hFF);
    check("t4_note0", note_of(0), 70);
`else
    check("t5_drop", got_drop, 1);
    check("t5_latency", cyc, 8);
    check("t5_gate", gate, 8'hFF);
    seen = alloc_stb;
    tick();
    check("t5_drop_pulse", drop_stb, 0);
    repeat (4) begin
      tick();
      seen |= alloc_stb;
    end
    check("t5_no_alloc", seen, 0);
    check("t5_note0", note_of(0), 60);
`endif

    // Oldest releasing voice wins over a younger releasing voice
    do_reset();
    for (int i = 0; i < 8; i++) note_on(7'(60 + i), 7'd64);
    note_off(7'd62);
    note_on(7'd80, 7'd10);
    check("t6_reuse2", alloc_voice, 2);
    note_off(7'd80);
    note_off(7'd65);
    env_idle = 8'hDB;
    note_on(7'd90, 7'd20);
    check("t6_latency", cyc, 9);
    check("t6_voice", alloc_voice, 5);
    check("t6_gate", gate, 8'hFB);
    check("t6_note5", note_of(5), 90);
    check("t6_note2_kept", note_of(2), 80);

    // Reset in the middle of a scan discards the event
    env_idle = 8'hFF;
    send(1'b1, 7'd100, 7'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_gate", gate, 8'h00);
    check("rst_mid_ready", ev_if.ev_ready, 1);
    check("rst_mid_note5", note_of(5), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      seen |= alloc_stb | drop_stb;
    end
    check("rst_mid_no_stb", seen, 0);
    note_on(7'd61, 7'd33);
    check("post_rst_latency", cyc, 9);
    check("post_rst_voice", alloc_voice, 0);
    check("post_rst_gate", gate, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
